// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BUB_W = 3;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_EXC_VEC  = 32'h0000_4180;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } pc_state_e;

  // A fetch target must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16
  import pc_pkg::*;
(
  input  logic             inc,
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pc_seq.sv
// Fetch program-counter sequencer: sequential fetch, branch redirects with
// flush bubbles, and misaligned-target exception redirect.
module pc_seq
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC       = DEF_EXC_VEC,
  parameter int unsigned FLUSH_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  output logic        br_ready_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
  output logic        exc_o,
  output logic [31:0] epc_o,
  output logic [15:0] redir_cnt_o
);

  pc_state_e        state_d, state_q;
  logic [XLEN-1:0]  pc_d, pc_q;
  logic [XLEN-1:0]  epc_d, epc_q;
  logic [BUB_W-1:0] bub_d, bub_q;
  logic             flush_d, flush_q;
  logic             exc_d, exc_q;
  logic             run;
  logic             handshake;

  assign run       = (state_q == RUN);
  assign handshake = br_valid_i && run;

  // Next-state: a redirect in RUN wins over stall; BUBBLE ignores br_valid_i.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    bub_d   = bub_q;
    flush_d = 1'b0;
    exc_d   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (handshake) begin
          flush_d = 1'b1;
          if (is_misaligned(br_target_i)) begin
            pc_d  = EXC_VEC;
            epc_d = br_target_i;
            exc_d = 1'b1;
          end else begin
            pc_d = br_target_i;
          end
          if (FLUSH_BUBBLES != 0) begin
            state_d = BUBBLE;
            bub_d   = BUB_W'(FLUSH_BUBBLES);
          end
        end else if (!stall_i) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      BUBBLE: begin
        if (!stall_i) begin
          if (bub_q <= BUB_W'(1)) begin
            bub_d   = '0;
            state_d = RUN;
          end else begin
            bub_d = bub_q - BUB_W'(1);
          end
        end
      end
      default: begin
        state_d = BOOT;
        bub_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      bub_q   <= '0;
      flush_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      bub_q   <= bub_d;
      flush_q <= flush_d;
      exc_q   <= exc_d;
    end
  end

  sat_cnt16 u_redir_cnt (
    .inc   (handshake),
    .clk   (clk),
    .rst_n (rst_n),
    .q     (redir_cnt_o)
  );

  assign br_ready_o    = run;
  assign fetch_valid_o = run;
  assign pc_o          = pc_q;
  assign npc_o         = pc_q + XLEN'(4);
  assign flush_o       = flush_q;
  assign exc_o         = exc_q;
  assign epc_o         = epc_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: three instances (1, 3 and 0 flush bubbles) against a
// behavioural model of the fetch sequence.
module tb_pc_seq;

  logic        clk;
  logic        rst_n [3];
  logic        stall [3];
  logic        bv    [3];
  logic [31:0] tgt   [3];
  logic        rdy   [3];
  logic [31:0] pc    [3];
  logic [31:0] npc   [3];
  logic        fv    [3];
  logic        fl    [3];
  logic        ex    [3];
  logic [31:0] epc   [3];
  logic [15:0] cnt   [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: boot flag, pc, remaining bubble cycles, last-cycle pulses, counters.
  bit          m_boot [3];
  logic [31:0] m_pc   [3];
  int          m_bub  [3];
  bit          m_fl   [3];
  bit          m_ex   [3];
  logic [31:0] m_epc  [3];
  int          m_cnt  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_seq #(.FLUSH_BUBBLES(1)) u_fb1 (
    .clk(clk), .rst_n(rst_n[0]), .stall_i(stall[0]), .br_valid_i(bv[0]),
    .br_target_i(tgt[0]), .br_ready_o(rdy[0]), .pc_o(pc[0]), .npc_o(npc[0]),
    .fetch_valid_o(fv[0]), .flush_o(fl[0]), .exc_o(ex[0]), .epc_o(epc[0]),
    .redir_cnt_o(cnt[0]));

  pc_seq #(.FLUSH_BUBBLES(3)) u_fb3 (
    .clk(clk), .rst_n(rst_n[1]), .stall_i(stall[1]), .br_valid_i(bv[1]),
    .br_target_i(tgt[1]), .br_ready_o(rdy[1]), .pc_o(pc[1]), .npc_o(npc[1]),
    .fetch_valid_o(fv[1]), .flush_o(fl[1]), .exc_o(ex[1]), .epc_o(epc[1]),
    .redir_cnt_o(cnt[1]));

  pc_seq #(.FLUSH_BUBBLES(0)) u_fb0 (
    .clk(clk), .rst_n(rst_n[2]), .stall_i(stall[2]), .br_valid_i(bv[2]),
    .br_target_i(tgt[2]), .br_ready_o(rdy[2]), .pc_o(pc[2]), .npc_o(npc[2]),
    .fetch_valid_o(fv[2]), .flush_o(fl[2]), .exc_o(ex[2]), .epc_o(epc[2]),
    .redir_cnt_o(cnt[2]));

  function automatic int fb_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic bit m_fv(input int k);
    return !m_boot[k] && (m_bub[k] == 0);
  endfunction

  task automatic model_reset(input int k);
    m_boot[k] = 1'b1;
    m_pc[k]   = 32'h0000_3000;
    m_bub[k]  = 0;
    m_fl[k]   = 1'b0;
    m_ex[k]   = 1'b0;
    m_epc[k]  = 32'h0;
    m_cnt[k]  = 0;
  endtask

  task automatic model_step(input int k);
    m_fl[k] = 1'b0;
    m_ex[k] = 1'b0;
    if (m_boot[k]) begin
      m_boot[k] = 1'b0;
    end else if (m_bub[k] > 0) begin
      if (!stall[k]) m_bub[k] = m_bub[k] - 1;
    end else if (bv[k]) begin
      m_fl[k] = 1'b1;
      if (tgt[k] % 4 != 0) begin
        m_pc[k]  = 32'h0000_4180;
        m_epc[k] = tgt[k];
        m_ex[k]  = 1'b1;
      end else begin
        m_pc[k] = tgt[k];
      end
      if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
      m_bub[k] = fb_of(k);
    end else if (!stall[k]) begin
      m_pc[k] = m_pc[k] + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) if (rst_n[k]) model_step(k);
    #1;
  endtask

  task automatic reset_inst(input int k);
    rst_n[k] = 1'b0;
    model_reset(k);
    tick();
    rst_n[k] = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (pc[k] !== 32'h0000_3000 || fv[k] !== 1'b0 || rdy[k] !== 1'b0 ||
          fl[k] !== 1'b0 || ex[k] !== 1'b0 || epc[k] !== 32'h0 || cnt[k] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: pc=%h fv=%b rdy=%b fl=%b ex=%b epc=%h cnt=%h, want 00003000 0 0 0 0 0 0",
                 k, pc[k], fv[k], rdy[k], fl[k], ex[k], epc[k], cnt[k]);
      end
    end
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h3000, 32'h3000, 32'h3004, 32'h3008, 32'h300C};
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (pc[0] !== exp_pc[i] || npc[0] !== exp_pc[i] + 32'd4 || fv[0] !== (i != 0)) begin
        n_fail++;
        $display("FAIL seq[%0d]: pc=%h npc=%h fv=%b, want pc=%h npc=%h fv=%b",
                 i, pc[0], npc[0], fv[0], exp_pc[i], exp_pc[i] + 32'd4, (i != 0));
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_redirect();
    stall[0] = 1'b1; bv[0] = 1'b1; tgt[0] = 32'h0000_3100;
    n_checks++;
    if (rdy[0] !== 1'b1) begin
      n_fail++; $display("FAIL redir_ready: got %b want 1", rdy[0]);
    end
    tick();
    stall[0] = 1'b0; bv[0] = 1'b0;
    n_checks++;
    if (pc[0] !== 32'h3100 || fl[0] !== 1'b1 || fv[0] !== 1'b0 || cnt[0] !== 16'd1 ||
        ex[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL redir: pc=%h fl=%b fv=%b cnt=%h ex=%b rdy=%b, want 00003100 1 0 0001 0 0",
               pc[0], fl[0], fv[0], cnt[0], ex[0], rdy[0]);
    end
    tick();
    n_checks++;
    if (pc[0] !== 32'h3100 || fl[0] !== 1'b0 || fv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_after: pc=%h fl=%b fv=%b, want 00003100 0 1", pc[0], fl[0], fv[0]);
    end
    tick();
    n_checks++;
    if (pc[0] !== 32'h3104) begin
      n_fail++; $display("FAIL redir_resume: pc=%h want 00003104", pc[0]);
    end
  endtask

  task automatic test_misaligned();
    bv[0] = 1'b1; tgt[0] = 32'h0000_3102;
    tick();
    bv[0] = 1'b0;
    n_checks++;
    if (pc[0] !== 32'h4180 || ex[0] !== 1'b1 || epc[0] !== 32'h3102 || fl[0] !== 1'b1 ||
        cnt[0] !== 16'd2) begin
      n_fail++;
      $display("FAIL misalign: pc=%h ex=%b epc=%h fl=%b cnt=%h, want 00004180 1 00003102 1 0002",
               pc[0], ex[0], epc[0], fl[0], cnt[0]);
    end
    tick();
    n_checks++;
    if (ex[0] !== 1'b0 || fl[0] !== 1'b0 || epc[0] !== 32'h3102 || fv[0] !== 1'b1 ||
        pc[0] !== 32'h4180) begin
      n_fail++;
      $display("FAIL misalign_after: ex=%b fl=%b epc=%h fv=%b pc=%h, want 0 0 00003102 1 00004180",
               ex[0], fl[0], epc[0], fv[0], pc[0]);
    end
  endtask

  task automatic test_wrap();
    bv[0] = 1'b1; tgt[0] = 32'hFFFF_FFFC;
    tick();
    bv[0] = 1'b0;
    tick();
    n_checks++;
    if (pc[0] !== 32'hFFFF_FFFC || npc[0] !== 32'h0 || fv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_top: pc=%h npc=%h fv=%b, want fffffffc 00000000 1", pc[0], npc[0], fv[0]);
    end
    tick();
    n_checks++;
    if (pc[0] !== 32'h0 || npc[0] !== 32'h4) begin
      n_fail++; $display("FAIL wrap: pc=%h npc=%h, want 00000000 00000004", pc[0], npc[0]);
    end
  endtask

  task automatic test_bubble_stall();
    int lows;
    lows = 0;
    stall[1] = 1'b0; bv[1] = 1'b1; tgt[1] = 32'h0000_6000;
    tick();
    // br_valid stays high through the bubble; it must not be taken again.
    while (fv[1] === 1'b0 && lows < 20) begin
      lows++;
      stall[1] = (lows <= 2);
      tick();
    end
    bv[1] = 1'b0; stall[1] = 1'b0;
    n_checks++;
    if (lows != 5) begin
      n_fail++; $display("FAIL bubble_len: got %0d invalid cycles want 5", lows);
    end
    n_checks++;
    if (cnt[1] !== 16'd1 || pc[1] !== 32'h6000) begin
      n_fail++;
      $display("FAIL bubble_ignore: cnt=%h pc=%h, want 0001 00006000", cnt[1], pc[1]);
    end
  endtask

  task automatic test_async_reset();
    stall[1] = 1'b1; bv[1] = 1'b1; tgt[1] = 32'h0000_5006;
    tick();
    bv[1] = 1'b0;
    n_checks++;
    if (fl[1] !== 1'b1 || ex[1] !== 1'b1 || epc[1] !== 32'h5006 || fv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_pre: fl=%b ex=%b epc=%h fv=%b, want 1 1 00005006 0",
               fl[1], ex[1], epc[1], fv[1]);
    end
    #2;
    rst_n[1] = 1'b0;
    model_reset(1);
    #1;
    n_checks++;
    if (pc[1] !== 32'h3000 || fl[1] !== 1'b0 || ex[1] !== 1'b0 || epc[1] !== 32'h0 ||
        cnt[1] !== 16'h0 || fv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_now: pc=%h fl=%b ex=%b epc=%h cnt=%h fv=%b, want 00003000 0 0 0 0 0",
               pc[1], fl[1], ex[1], epc[1], cnt[1], fv[1]);
    end
    #2;
    rst_n[1] = 1'b1;
    stall[1] = 1'b0;
    tick();
    n_checks++;
    if (fv[1] !== 1'b1 || pc[1] !== 32'h3000 || fl[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_boot: fv=%b pc=%h fl=%b, want 1 00003000 0", fv[1], pc[1], fl[1]);
    end
    tick();
    n_checks++;
    if (pc[1] !== 32'h3004) begin
      n_fail++; $display("FAIL arst_run: pc=%h want 00003004", pc[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        stall[k] = ($urandom_range(0, 3) == 0);
        if (!(bv[k] && !rdy[k])) begin
          bv[k] = ($urandom_range(0, 3) == 0);
          case ($urandom_range(0, 3))
            0: tgt[k] = $urandom() & 32'hFFFF_FFFC;
            1: tgt[k] = $urandom();
            2: tgt[k] = 32'hFFFF_FFFC;
            default: tgt[k] = m_pc[k] + 32'd8;
          endcase
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (pc[k] !== m_pc[k] || npc[k] !== m_pc[k] + 32'd4 || fv[k] !== m_fv(k) ||
            rdy[k] !== m_fv(k) || fl[k] !== m_fl[k] || ex[k] !== m_ex[k] ||
            epc[k] !== m_epc[k] || cnt[k] !== 16'(m_cnt[k])) begin
          n_fail++;
          $display("FAIL rand[%0d] c=%0d: pc=%h fv=%b fl=%b ex=%b epc=%h cnt=%h, want %h %b %b %b %h %h",
                   k, c, pc[k], fv[k], fl[k], ex[k], epc[k], cnt[k],
                   m_pc[k], m_fv(k), m_fl[k], m_ex[k], m_epc[k], 16'(m_cnt[k]));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      bv[k] = 1'b0; stall[k] = 1'b0;
    end
  endtask

  task automatic test_saturation();
    int no_flush;
    no_flush = 0;
    reset_inst(2);
    tick();
    bv[2] = 1'b1; tgt[2] = 32'h0000_0100;
    for (int i = 1; i <= 65537; i++) begin
      stall[2] = $urandom_range(0, 1) == 1;
      tick();
      if (fl[2] !== 1'b1) no_flush++;
      if (i == 65534) begin
        n_checks++;
        if (cnt[2] !== 16'hFFFE) begin
          n_fail++; $display("FAIL sat_near: cnt=%h want fffe", cnt[2]);
        end
      end
    end
    bv[2] = 1'b0;
    n_checks++;
    if (cnt[2] !== 16'hFFFF || cnt[2] !== 16'(m_cnt[2])) begin
      n_fail++; $display("FAIL sat: cnt=%h want ffff", cnt[2]);
    end
    n_checks++;
    if (no_flush != 0) begin
      n_fail++; $display("FAIL sat_flush: %0d cycles without flush, want 0", no_flush);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; stall[k] = 1'b0; bv[k] = 1'b0; tgt[k] = 32'h0;
      model_reset(k);
    end
    test_reset();
    test_sequential();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_bubble_stall();
    test_async_reset();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning first fetch address after reset.
REQ-002 SHALL have parameter EXC_VEC, default 32'h0000_4180, meaning redirect address on a misaligned branch target.
REQ-003 SHALL have parameter FLUSH_BUBBLES, default 1, range 0..7, meaning fetch-invalid cycles after a redirect.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 stall_i  in  1  pipeline hold; PC frozen when no redirect is taken.
REQ-006 br_valid_i  in  1  redirect request from the branch-target adder.
REQ-007 br_target_i  in  32  redirect target byte address (npc + 4*offset, computed upstream).
REQ-008 br_ready_o  out  1  redirect accepted this cycle when high together with br_valid_i.
REQ-009 pc_o  out  32  current fetch address, registered.
REQ-010 npc_o  out  32  pc_o + 4, combinational; feeds the branch-target adder.
REQ-011 fetch_valid_o  out  1  pc_o is a valid fetch this cycle.
REQ-012 flush_o  out  1  one-cycle pulse, registered, after every accepted redirect.
REQ-013 exc_o  out  1  one-cycle pulse, registered, after a misaligned redirect.
REQ-014 epc_o  out  32  last misaligned target captured.
REQ-015 redir_cnt_o  out  16  count of accepted redirects, saturating.

Function
REQ-016 The FSM SHALL have three states: BOOT, RUN and BUBBLE.
REQ-017 BOOT SHALL last exactly one cycle after reset release, then go to RUN, regardless of inputs; in BOOT fetch_valid_o=0 and br_ready_o=0.
REQ-018 fetch_valid_o and br_ready_o SHALL be combinational and equal 1 only in RUN.
REQ-019 In RUN, a handshake (br_valid_i & br_ready_o) with br_target_i[1:0]==0 SHALL load pc_o<=br_target_i at the next edge.
REQ-020 In RUN, a handshake with br_target_i[1:0]!=0 SHALL load pc_o<=EXC_VEC and epc_o<=br_target_i, and pulse exc_o for the next cycle.
REQ-021 Every handshake SHALL pulse flush_o for exactly the next cycle and increment redir_cnt_o, holding it at 16'hFFFF once reached.
REQ-022 After a handshake, the FSM SHALL enter BUBBLE with bubble counter = FLUSH_BUBBLES; if FLUSH_BUBBLES==0 it SHALL stay in RUN.
REQ-023 A handshake SHALL take priority over stall_i in the same cycle.
REQ-024 In RUN with no handshake, stall_i=1 SHALL hold pc_o; stall_i=0 SHALL set pc_o<=pc_o+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-025 In BUBBLE, pc_o SHALL hold and br_valid_i SHALL be ignored; the counter decrements when stall_i=0, freezes when stall_i=1, and the FSM returns to RUN on the edge where the counter goes 1->0.
REQ-026 An unaccepted br_valid_i SHALL have no effect; upstream keeps it asserted until accepted.

Reset
REQ-027 On rst_n=0, asynchronously: pc_o=RESET_PC, state=BOOT, bubble counter=0, flush_o=0, exc_o=0, epc_o=0, redir_cnt_o=0.
REQ-028 Reset asserted mid-BUBBLE or mid-redirect SHALL discard the pending redirect and pulses entirely.

Structure
REQ-029 Package pc_pkg SHALL hold the state enum (BOOT, RUN, BUBBLE) and the default RESET_PC/EXC_VEC constants.
REQ-030 The saturating redirect counter SHALL be a sub-module sat_cnt16 (inc, clk, rst_n, q[15:0]); all other logic stays in pc_seq.

Verification
REQ-031 Reset then 4 unstalled cycles -> pc_o 3000 (fetch_valid 0), 3000, 3004, 3008, 300C; npc_o always pc_o+4.
REQ-032 In RUN, br_valid=1 with target 32'h0000_3100 and stall_i=1 -> next pc_o=3100, flush_o=1 for 1 cycle, fetch_valid 0 for 1 cycle (FLUSH_BUBBLES=1), redir_cnt_o=1.
REQ-033 Target 32'h0000_3102 -> pc_o=4180, exc_o=1 for 1 cycle, epc_o=3102, flush_o=1.
REQ-034 FLUSH_BUBBLES=3 with stall_i high for 2 cycles during BUBBLE -> fetch_valid low for 5 cycles; br_valid during BUBBLE is not accepted.
REQ-035 Force pc to FFFF_FFFC via redirect and run unstalled -> pc_o wraps to 0000_0000; 65537 redirects -> redir_cnt_o=FFFF.
REQ-036 rst_n low for a fraction of a cycle during BUBBLE -> outputs return to reset values immediately; BOOT follows release.
